// File: rtl/pcihellocore_ledred_pkg.sv
// Shared definitions for the red-LED driver: display modes, PIO word field
// positions and the PWM period.
package pcihellocore_ledred_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10
  } mode_e;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DUTY_LSB   = 18;
  localparam int unsigned DUTY_W     = 6;
  localparam int unsigned MODE_LSB   = 24;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned RATE_LSB   = 26;
  localparam int unsigned RATE_W     = 4;
  localparam int unsigned PWM_PERIOD = 63;

  // Raw mode field to enum; the reserved encoding 11 falls back to steady.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] m);
    case (m)
      2'b01:   return MODE_BLINK;
      2'b10:   return MODE_CHASE;
      default: return MODE_STEADY;
    endcase
  endfunction

  // Perceptual duty curve: (D*(D+1))>>6, keeps 0->0 and 63->63.
  function automatic logic [DUTY_W-1:0] gamma_duty(input logic [DUTY_W-1:0] d);
    logic [11:0] p;
    p = 12'(d) * (12'(d) + 12'd1);
    return DUTY_W'(p >> 6);
  endfunction

endpackage

// File: rtl/pcihellocore_ledred_tick.sv
// Restartable blink/chase tick divider.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   restart      : clears the divider (takes priority over counting)
//   rate         : R, period is BLINK_BASE*(R+1) clocks
//   tick         : registered one-cycle pulse at the end of each period
module pcihellocore_ledred_tick
  import pcihellocore_ledred_pkg::*;
#(
  parameter int unsigned BLINK_BASE = 1_562_500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  localparam int unsigned MAX_PERIOD = BLINK_BASE * 16;
  localparam int unsigned CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit_c;

  assign limit_c = CNT_W'(BLINK_BASE * (32'(rate) + 32'd1) - 32'd1);

  // Divider: count to limit, pulse and wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q >= limit_c) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/pcihellocore_ledred_drv.sv
// Red-LED driver behind the PIO: global PWM brightness with steady, blink
// and chase display modes. The PIO word is shadowed once per PWM frame so
// the LEDs never show a partially applied word.
// Optional build macro: LEDRED_GAMMA_EN (perceptual duty curve).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   led_word     : PIO output word (mask / duty / mode / rate)
//   ledr         : registered LED drive, 1 = lit
//   frame_strobe : one-cycle pulse on each PWM frame boundary (shadow load)
module pcihellocore_ledred_drv
  import pcihellocore_ledred_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 18,
  parameter int unsigned PWM_DIV    = 8,
  parameter int unsigned BLINK_BASE = 1_562_500
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WORD_W-1:0]   led_word,
  output logic [NUM_LEDS-1:0] ledr,
  output logic                frame_strobe
);

  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [WORD_W-1:0]   word_q, word_s;
  logic [1:0]          start_q;
  logic [PRE_W-1:0]    presc_q;
  logic [5:0]          pwm_cnt;
  logic [DUTY_W-1:0]   d_eff_q;
  logic                phase;
  logic [NUM_LEDS-1:0] pattern;
  logic                tick;

  logic                boundary_c, load_c, pwm_on_c;
  logic                mode_chg_c, mask_chg_c, restart_c;
  mode_e               mode_s_c, mode_n_c;
  logic [DUTY_W-1:0]   d_next_c;
  logic [NUM_LEDS-1:0] mask_s_c, mask_n_c, ledr_next_c;
  logic                unused_bits;

  assign unused_bits = ^{word_q[WORD_W-1:RATE_LSB+RATE_W], word_s[WORD_W-1:RATE_LSB+RATE_W]};

  function automatic logic [NUM_LEDS-1:0] rotl(input logic [NUM_LEDS-1:0] p);
    return (p << 1) | (p >> (NUM_LEDS - 1));
  endfunction

  // Frame boundary and shadow-load decode; the extra load right after reset
  // picks up the first captured word without waiting a whole frame.
  always_comb begin
    boundary_c = (presc_q == PRE_W'(PWM_DIV - 1)) && (pwm_cnt == 6'(PWM_PERIOD - 1));
    load_c     = boundary_c || (start_q == 2'd1);
    mode_s_c   = decode_mode(word_s[MODE_LSB +: MODE_W]);
    mode_n_c   = decode_mode(word_q[MODE_LSB +: MODE_W]);
    mask_s_c   = word_s[NUM_LEDS-1:0];
    mask_n_c   = word_q[NUM_LEDS-1:0];
    mode_chg_c = load_c && (mode_n_c != mode_s_c);
    mask_chg_c = load_c && (mode_n_c == MODE_CHASE) && (mask_n_c != mask_s_c);
    restart_c  = mode_chg_c ||
                 (load_c && (word_q[RATE_LSB +: RATE_W] != word_s[RATE_LSB +: RATE_W]));
`ifdef LEDRED_GAMMA_EN
    d_next_c   = gamma_duty(word_q[DUTY_LSB +: DUTY_W]);
`else
    d_next_c   = word_q[DUTY_LSB +: DUTY_W];
`endif
  end

  // LED decision from the shadow word, registered below.
  always_comb begin
    pwm_on_c    = (pwm_cnt < 6'(d_eff_q));
    ledr_next_c = '0;
    case (mode_s_c)
      MODE_BLINK: ledr_next_c = mask_s_c & {NUM_LEDS{pwm_on_c & phase}};
      MODE_CHASE: ledr_next_c = pattern & {NUM_LEDS{pwm_on_c}};
      default:    ledr_next_c = mask_s_c & {NUM_LEDS{pwm_on_c}};
    endcase
  end

  pcihellocore_ledred_tick #(
    .BLINK_BASE (BLINK_BASE)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart_c),
    .rate    (word_s[RATE_LSB +: RATE_W]),
    .tick    (tick)
  );

  // Main state: input capture, PWM counters, shadow word, phase/pattern.
  // A mode change or chase mask change at load outranks a same-cycle tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q       <= '0;
      word_s       <= '0;
      start_q      <= 2'd0;
      presc_q      <= '0;
      pwm_cnt      <= '0;
      d_eff_q      <= '0;
      phase        <= 1'b1;
      pattern      <= '0;
      ledr         <= '0;
      frame_strobe <= 1'b0;
    end else begin
      word_q       <= led_word;
      frame_strobe <= boundary_c;
      ledr         <= ledr_next_c;

      if (start_q != 2'd2) start_q <= start_q + 2'd1;

      if (presc_q == PRE_W'(PWM_DIV - 1)) begin
        presc_q <= '0;
        pwm_cnt <= (pwm_cnt == 6'(PWM_PERIOD - 1)) ? 6'd0 : pwm_cnt + 6'd1;
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end

      if (load_c) begin
        word_s  <= word_q;
        d_eff_q <= d_next_c;
      end

      if (mode_chg_c)  phase <= 1'b1;
      else if (tick)   phase <= ~phase;

      if (mode_chg_c || mask_chg_c)             pattern <= mask_n_c;
      else if (tick && mode_s_c == MODE_CHASE)  pattern <= rotl(pattern);
    end
  end

endmodule

// File: tb/tb_pcihellocore_ledred_drv.sv
// Scoreboard bench for pcihellocore_ledred_drv (PWM_DIV=2, BLINK_BASE=4).
// Stimulus pushes per-cycle expected ledr/frame_strobe keyed by absolute
// cycle; the monitor pops and compares on the falling edge.
// Edge k after release: word_s valid from k=2, ledr from k=3, frame
// boundaries (shadow loads) at k=126, 252.
module tb_pcihellocore_ledred_drv;

  localparam int unsigned N = 18;

`ifdef LEDRED_GAMMA_EN
  localparam int unsigned DE32 = 16;
`else
  localparam int unsigned DE32 = 32;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   led_word = 32'h0;
  logic [N-1:0]  ledr;
  logic          frame_strobe;

  always #5 clk = ~clk;

  pcihellocore_ledred_drv #(
    .NUM_LEDS   (N),
    .PWM_DIV    (2),
    .BLINK_BASE (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .led_word     (led_word),
    .ledr         (ledr),
    .frame_strobe (frame_strobe)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] ledr;
    logic         strobe;
    logic         chk_int;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int unsigned c, input logic [N-1:0] l,
                      input logic s, input logic ci);
    exp_t e;
    e.cyc = c; e.ledr = l; e.strobe = s; e.chk_int = ci;
    sbq.push_back(e);
  endtask

  function automatic logic strobe_exp(input int unsigned k);
    return (k != 0) && (k % 126 == 0);
  endfunction

  // Single lit LED walking from bit 0 every 8 cycles (mask 1, R=1).
  function automatic logic [N-1:0] chase_exp(input int unsigned k);
    if (k < 3)  return '0;
    if (k == 3) return N'(1);
    return N'(1) << (((k - 4) / 8) % 18);
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL stale_expect cyc=%0d now=%0d", e.cyc, cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if (ledr !== e.ledr) begin
        n_bad++;
        $display("FAIL ledr cyc=%0d got=%05h want=%05h", cyc, ledr, e.ledr);
      end
      n_cmp++;
      if (frame_strobe !== e.strobe) begin
        n_bad++;
        $display("FAIL frame_strobe cyc=%0d got=%b want=%b", cyc, frame_strobe, e.strobe);
      end
      if (e.chk_int) begin
        n_cmp++;
        if (dut.phase !== 1'b1) begin
          n_bad++;
          $display("FAIL reset_phase cyc=%0d got=%b want=1", cyc, dut.phase);
        end
        n_cmp++;
        if (dut.pattern !== '0) begin
          n_bad++;
          $display("FAIL reset_pattern cyc=%0d got=%05h want=00000", cyc, dut.pattern);
        end
      end
    end
  end

  // Apply word under reset for 3 edges, release; returns base so edge k = base+k.
  task automatic start(input logic [31:0] w, output int unsigned base);
    led_word = w;
    reset_n  = 1'b0;
    for (int i = 1; i <= 3; i++) push(cyc + i, '0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base    = cyc;
  endtask

  task automatic wait_k(input int unsigned base, input int unsigned k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout left=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int unsigned b;
    logic [N-1:0] v;
    @(negedge clk);

    // PIO reset value: all 18 LEDs full on, steady
    start(32'h00FF_FFFF, b);
    for (int unsigned k = 1; k <= 260; k++)
      push(b + k, (k >= 3) ? 18'h3FFFF : 18'h0, strobe_exp(k), 1'b0);
    drain();

    // D=32 on LED0: 64 of 126 cycles lit (32 with gamma)
    start(32'h0080_0001, b);
    for (int unsigned k = 1; k <= 260; k++) begin
      v = (k >= 3 && ((k - 1) / 2) % 63 < DE32) ? 18'h1 : 18'h0;
      push(b + k, v, strobe_exp(k), 1'b0);
    end
    drain();

    // Blink LEDs 0-1, D=63, R=0: lit k=3..7, then 4 off / 4 on
    start(32'h01FC_0003, b);
    for (int unsigned k = 1; k <= 140; k++) begin
      if (k < 3)                 v = '0;
      else if (k == 3)           v = 18'h3;
      else if ((k / 4) % 2 == 1) v = 18'h3;
      else                       v = '0;
      push(b + k, v, strobe_exp(k), 1'b0);
    end
    drain();

    // Chase mask 1, R=1; mask -> 3 written mid-frame, reloaded at k=252
    start(32'h06FC_0001, b);
    for (int unsigned k = 1; k <= 270; k++) begin
      if (k <= 252)      v = chase_exp(k);
      else if (k <= 259) v = 18'h3;
      else if (k <= 267) v = 18'h6;
      else               v = 18'hC;
      push(b + k, v, strobe_exp(k), 1'b0);
    end
    wait_k(b, 160);
    led_word = 32'h06FC_0003;
    drain();

    // Mid-frame write held until boundary; write just before boundary lands 2 cycles later
    start(32'h00FF_FFFF, b);
    for (int unsigned k = 1; k <= 260; k++) begin
      if (k < 3)         v = '0;
      else if (k <= 126) v = 18'h3FFFF;
      else if (k <= 252) v = 18'h00155;
      else               v = 18'h00AAA;
      push(b + k, v, strobe_exp(k), 1'b0);
    end
    wait_k(b, 40);
    led_word = 32'h00FC_0155;
    wait_k(b, 250);
    led_word = 32'h00FC_0AAA;
    drain();

    // Reset during chase: next edge clears ledr, phase=1, pattern=0
    start(32'h06FC_0001, b);
    for (int unsigned k = 1; k <= 50; k++)
      push(b + k, chase_exp(k), strobe_exp(k), 1'b0);
    push(b + 51, '0, 1'b0, 1'b1);
    push(b + 52, '0, 1'b0, 1'b1);
    wait_k(b, 50);
    reset_n = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
